dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder with configurable wait states and byte-lane stores.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses through dmem_err_o.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wen_i,
  input  logic [3:0]  dmem_ben_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_rvalid_o,
  output logic        dmem_stall_o,
  output logic        dmem_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_off;
  logic          r_wen;
  logic [3:0]    r_ben;
  logic [31:0]   r_wdata;
  logic          r_rvalid;
  logic [31:0]   r_rdata;

  logic [1:0]    w_state_nxt;
  logic          w_capture;
  logic          w_to_resp;
  logic [AW-1:0] w_src_idx;
  logic [1:0]    w_src_off;
  logic          w_src_wen;
  logic [3:0]    w_src_ben;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_rdata_nxt;
  logic          w_src_mis;
  logic          w_wr_block;
  logic [3:0]    w_ben_eff;
  logic [31:0]   w_wdata_sh;
  logic          w_unused_addr;

  // Address bits above the array depth wrap around and are intentionally ignored.
  assign w_unused_addr = ^dmem_addr_i[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_err;

  function automatic logic is_misaligned(input logic [1:0] off, input logic [3:0] ben);
    is_misaligned = ((ben == 4'b0011) && (off == 2'd3)) ||
                    ((ben == 4'b1111) && (off != 2'd0));
  endfunction

  assign w_src_mis  = is_misaligned(w_src_off, w_src_ben);
  assign w_wr_block = r_err;
  assign dmem_err_o = r_err;
`else
  assign w_src_mis  = 1'b0;
  assign w_wr_block = 1'b0;
  assign dmem_err_o = 1'b0;
`endif

  // Next-state logic for the IDLE/BUSY/RESP handshake
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_to_resp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem_req_i) begin
          w_capture = 1'b1;
          if (WAIT_L == 4'd0) begin
            w_state_nxt = S_RESP;
            w_to_resp   = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_to_resp   = 1'b1;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the live request feeds the read path.
  always_comb begin
    w_src_idx = r_idx;
    w_src_off = r_off;
    w_src_wen = r_wen;
    w_src_ben = r_ben;
    if (r_state == S_IDLE) begin
      w_src_idx = dmem_addr_i[AW+1:2];
      w_src_off = dmem_addr_i[1:0];
      w_src_wen = dmem_wen_i;
      w_src_ben = dmem_ben_i;
    end else begin
      w_src_idx = r_idx;
      w_src_off = r_off;
      w_src_wen = r_wen;
      w_src_ben = r_ben;
    end
  end

  assign w_rd_word = r_mem[w_src_idx];

  // Load data is registered on entry to RESP and zero at all other times
  always_comb begin
    w_rdata_nxt = 32'h0000_0000;
    if (w_to_resp && !w_src_wen && !w_src_mis) begin
      w_rdata_nxt = w_rd_word >> {w_src_off, 3'b000};
    end else begin
      w_rdata_nxt = 32'h0000_0000;
    end
  end

  // Control, capture and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_off    <= 2'd0;
      r_wen    <= 1'b0;
      r_ben    <= 4'd0;
      r_wdata  <= 32'h0000_0000;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_to_resp;
      r_rdata  <= w_rdata_nxt;
      if (w_capture) begin
        r_idx   <= dmem_addr_i[AW+1:2];
        r_off   <= dmem_addr_i[1:0];
        r_wen   <= dmem_wen_i;
        r_ben   <= dmem_ben_i;
        r_wdata <= dmem_wdata_i;
        r_cnt   <= WAIT_L;
      end else if (r_state == S_BUSY) begin
        r_cnt   <= r_cnt - 4'd1;
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  // Misalignment flag, valid only during the RESP cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_to_resp & w_src_mis;
    end
  end
`endif

  assign w_ben_eff  = r_ben << r_off;
  assign w_wdata_sh = r_wdata << {r_off, 3'b000};

  // Store commit; the array itself is never reset, and reset forces IDLE so a pending store is dropped
  always_ff @(posedge clk_i) begin
    if ((r_state == S_RESP) && r_wen && !w_wr_block) begin
      for (int i = 0; i < 4; i++) begin
        if (w_ben_eff[i]) begin
          r_mem[r_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign dmem_rvalid_o = r_rvalid;
  assign dmem_rdata_o  = r_rdata;
  assign dmem_stall_o  = rst_n_i & (((r_state == S_IDLE) & dmem_req_i) | (r_state == S_BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 3 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [3];
  logic [31:0] addr  [3];
  logic        wen   [3];
  logic [3:0]  ben   [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rvalid[3];
  logic        stall [3];
  logic        err   [3];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_req_i(req[0]), .dmem_addr_i(addr[0]),
    .dmem_wen_i(wen[0]), .dmem_ben_i(ben[0]), .dmem_wdata_i(wdata[0]),
    .dmem_rdata_o(rdata[0]), .dmem_rvalid_o(rvalid[0]), .dmem_stall_o(stall[0]),
    .dmem_err_o(err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_req_i(req[1]), .dmem_addr_i(addr[1]),
    .dmem_wen_i(wen[1]), .dmem_ben_i(ben[1]), .dmem_wdata_i(wdata[1]),
    .dmem_rdata_o(rdata[1]), .dmem_rvalid_o(rvalid[1]), .dmem_stall_o(stall[1]),
    .dmem_err_o(err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_req_i(req[2]), .dmem_addr_i(addr[2]),
    .dmem_wen_i(wen[2]), .dmem_ben_i(ben[2]), .dmem_wdata_i(wdata[2]),
    .dmem_rdata_o(rdata[2]), .dmem_rvalid_o(rvalid[2]), .dmem_stall_o(stall[2]),
    .dmem_err_o(err[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       wait_of = 1;
      1:       wait_of = 0;
      default: wait_of = 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge after the RESP cycle.
  task automatic do_acc(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, input bit hold, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    int k;
    int n_stall;
    bit seen;
    req[d] = 1'b1; wen[d] = w; addr[d] = a; ben[d] = b; wdata[d] = wd;
    #1;
    n_stall = stall[d] ? 1 : 0;
    chk({tag, ".rv_early"}, 32'(rvalid[d]), 32'd0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (rvalid[d]) seen = 1'b1;
      else if (stall[d]) n_stall++;
    end
    chk({tag, ".seen"}, 32'(seen), 32'd1);
    chk({tag, ".lat"}, 32'(k), 32'(1 + wait_of(d)));
    chk({tag, ".stall_cyc"}, 32'(n_stall), 32'(1 + wait_of(d)));
    chk({tag, ".resp_stall"}, 32'(stall[d]), 32'd0);
    chk({tag, ".rdata"}, rdata[d], exp_rd);
    chk({tag, ".err"}, 32'(err[d]), 32'(exp_err));
    if (!hold) req[d] = 1'b0;
    @(negedge clk);
    chk({tag, ".rv_after"}, 32'(rvalid[d]), 32'd0);
    if (!hold) chk({tag, ".rd_after"}, rdata[d], 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = 32'd0; wen[i] = 1'b0; ben[i] = 4'd0; wdata[i] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst.rvalid", 32'(rvalid[i]), 32'd0);
      chk("rst.stall",  32'(stall[i]),  32'd0);
      chk("rst.rdata",  rdata[i],       32'd0);
      chk("rst.err",    32'(err[i]),    32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // word store then load, one wait state
    do_acc(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "w1_st_word");
    do_acc(0, 1'b0, 32'h10, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, "w1_ld_word");

    // byte and half-word lanes
    do_acc(0, 1'b1, 32'h10, 4'b1111, 32'h11223344, 1'b0, 32'h0, 1'b0, "st_base");
    do_acc(0, 1'b1, 32'h13, 4'b0001, 32'h000000AA, 1'b0, 32'h0, 1'b0, "st_byte3");
    do_acc(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'hAA223344, 1'b0, "ld_word_b");
    do_acc(0, 1'b0, 32'h13, 4'b0001, 32'h0, 1'b0, 32'h000000AA, 1'b0, "ld_byte3");
    do_acc(0, 1'b1, 32'h12, 4'b0011, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, "st_half2");
    do_acc(0, 1'b0, 32'h12, 4'b0011, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, "ld_half2");
    do_acc(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, "st_noben");
    do_acc(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'hBEEF3344, 1'b0, "ld_after_noben");

    // zero wait states and address wrap
    do_acc(1, 1'b1, 32'h1000, 4'b1111, 32'h5, 1'b0, 32'h0, 1'b0, "w0_st_wrap");
    do_acc(1, 1'b0, 32'h0,    4'b1111, 32'h0, 1'b0, 32'h5, 1'b0, "w0_ld_wrap");

    // misaligned word store and load
    do_acc(0, 1'b1, 32'h20, 4'b1111, 32'h01020304, 1'b0, 32'h0, 1'b0, "st_base20");
`ifdef DMEM_MISALIGN_CHECK_EN
    do_acc(0, 1'b1, 32'h21, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, "mis_st");
    do_acc(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 32'h01020304, 1'b0, "mis_ld20");
    do_acc(0, 1'b0, 32'h21, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, "mis_ld21");
`else
    do_acc(0, 1'b1, 32'h21, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, "mis_st");
    do_acc(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 32'hFFFFFF04, 1'b0, "mis_ld20");
    do_acc(0, 1'b0, 32'h21, 4'b1111, 32'h0, 1'b0, 32'h00FFFFFF, 1'b0, "mis_ld21");
`endif

    // reset during BUSY discards the pending store
    do_acc(2, 1'b1, 32'h40, 4'b1111, 32'h12345678, 1'b0, 32'h0, 1'b0, "w3_st_prior");
    req[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h40; ben[2] = 4'b1111; wdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    chk("w3_busy.stall", 32'(stall[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("w3_rst.rvalid", 32'(rvalid[2]), 32'd0);
    chk("w3_rst.stall",  32'(stall[2]),  32'd0);
    chk("w3_rst.rdata",  rdata[2],       32'd0);
    chk("w3_rst.err",    32'(err[2]),    32'd0);
    @(negedge clk);
    req[2] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_acc(2, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, 32'h12345678, 1'b0, "w3_ld_prior");

    // request held through RESP is taken again only in the following IDLE cycle
    do_acc(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b1, 32'hBEEF3344, 1'b0, "hold_first");
    chk("hold_idle.stall", 32'(stall[0]), 32'd1);
    do_acc(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 32'hBEEF3344, 1'b0, "hold_second");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
